// File: rtl/fusion_array_ctrl_pkg.sv
// rtl/fusion_array_ctrl_pkg.sv - width constants, FSM states and lane helpers for fusion_array_ctrl
package fusion_pkg;

    localparam logic [3:0] W1 = 4'b0001;
    localparam logic [3:0] W2 = 4'b0010;
    localparam logic [3:0] W4 = 4'b0100;
    localparam logic [3:0] W8 = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic is_legal_width(input logic [3:0] w);
        return (w == W1) || (w == W2) || (w == W4) || (w == W8);
    endfunction

    // The array has no 1-bit mode; 1-bit operands ride in the 2-bit datapath.
    function automatic logic [3:0] promote_width(input logic [3:0] w);
        return (w == W1) ? W2 : w;
    endfunction

    function automatic logic [1:0] lanes_log2(input logic [3:0] mode);
        case (mode)
            W2:      return 2'd2;
            W4:      return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] lanes_from_mode(input logic [3:0] mode);
        return 4'd1 << lanes_log2(mode);
    endfunction

endpackage

// File: rtl/fusion_array_ctrl_if.sv
// rtl/fusion_array_ctrl_if.sv - job, operand, array and result signals; FUSION_CTRL_PERF_EN adds perf counters
interface fusion_array_ctrl_if #(
    parameter int COL_WIDTH = 11,
    parameter int LEN_W     = 16
);
    logic                   start;
    logic [3:0]             cfg_in_width;
    logic [3:0]             cfg_weight_width;
    logic                   cfg_s_in;
    logic                   cfg_s_weight;
    logic [LEN_W-1:0]       cfg_len;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic                   op_valid;
    logic                   op_ready;
    logic [3:0]             arr_in_width;
    logic [3:0]             arr_weight_width;
    logic                   arr_s_in;
    logic                   arr_s_weight;
    logic                   arr_feed;
    logic [4*COL_WIDTH-1:0] arr_psum;
    logic                   res_valid;
    logic                   res_ready;
    logic [4*COL_WIDTH-1:0] res_data;
`ifdef FUSION_CTRL_PERF_EN
    logic [31:0]            perf_stall_cycles;
    logic [31:0]            perf_beats;
`endif

    modport slave (
        input  start, cfg_in_width, cfg_weight_width, cfg_s_in, cfg_s_weight, cfg_len,
        input  op_valid, arr_psum, res_ready,
        output busy, done, err, op_ready, arr_in_width, arr_weight_width,
        output arr_s_in, arr_s_weight, arr_feed, res_valid, res_data
`ifdef FUSION_CTRL_PERF_EN
        , output perf_stall_cycles, perf_beats
`endif
    );

    modport master (
        output start, cfg_in_width, cfg_weight_width, cfg_s_in, cfg_s_weight, cfg_len,
        output op_valid, arr_psum, res_ready,
        input  busy, done, err, op_ready, arr_in_width, arr_weight_width,
        input  arr_s_in, arr_s_weight, arr_feed, res_valid, res_data
`ifdef FUSION_CTRL_PERF_EN
        , input perf_stall_cycles, perf_beats
`endif
    );

endinterface

// File: rtl/fusion_array_ctrl_res_fifo.sv
// rtl/fusion_array_ctrl_res_fifo.sv - synchronous result FIFO with count/full/empty
module fusion_res_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    assign pop_ok = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = push   ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Head is forced to zero when empty so stale storage never leaks out.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/fusion_array_ctrl.sv
// rtl/fusion_array_ctrl.sv - fusion-unit column sequencer; FUSION_CTRL_PERF_EN adds stall/beat counters
module fusion_array_ctrl
    import fusion_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COL_WIDTH  = 11,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fusion_array_ctrl_if.slave bus
);
    localparam int PSUM_W = 4*COL_WIDTH;
    localparam int CNT_W  = $clog2(FIFO_DEPTH+1);
    localparam int INF_W  = $clog2(ROWS+1);
    localparam int CRD_W  = $clog2(FIFO_DEPTH+ROWS+1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] words_left_q, words_left_d;
    logic [ROWS-1:0]  flight_q, flight_d;
    logic [INF_W-1:0] inflight_q, inflight_d;
    logic [3:0]       in_w_q, wt_w_q;
    logic             s_in_q, s_wt_q;
    logic             err_q;

    logic [3:0]       in_p, wt_p, mode;
    logic [LEN_W:0]   k_round;
    logic [LEN_W-1:0] words;
    logic             cfg_ok, accept_start, reject_start;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    logic             op_ready, feed, push, pop, credit_ok, drain_empty;

    assign cfg_ok       = is_legal_width(bus.cfg_in_width) && is_legal_width(bus.cfg_weight_width);
    assign accept_start = (state_q == S_IDLE) && bus.start && cfg_ok;
    assign reject_start = (state_q == S_IDLE) && bus.start && !cfg_ok;

    assign in_p    = promote_width(bus.cfg_in_width);
    assign wt_p    = promote_width(bus.cfg_weight_width);
    assign mode    = (in_p > wt_p) ? in_p : wt_p;
    assign k_round = {1'b0, bus.cfg_len} + (LEN_W+1)'(lanes_from_mode(mode) - 4'd1);
    assign words   = LEN_W'(k_round >> lanes_log2(mode));

    // Credits cover both beats still in the array and results parked in the FIFO.
    assign credit_ok = (CRD_W'(inflight_q) + CRD_W'(fifo_count) < CRD_W'(FIFO_DEPTH)) && !fifo_full;
    assign op_ready  = (state_q == S_RUN) && (words_left_q != '0) && credit_ok;
    assign feed      = bus.op_valid && op_ready;
    assign push      = flight_q[ROWS-1];
    assign pop       = bus.res_ready && !fifo_empty;
    assign drain_empty = fifo_empty || ((fifo_count == CNT_W'(1)) && pop);

    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        flight_d     = {flight_q[ROWS-2:0], feed};
        inflight_d   = inflight_q + INF_W'(feed) - INF_W'(push);
        case (state_q)
            S_IDLE: begin
                if (accept_start) begin
                    words_left_d = words;
                    state_d      = (bus.cfg_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (feed) begin
                    words_left_d = words_left_q - LEN_W'(1);
                    if (words_left_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((inflight_q == '0) && drain_empty) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            words_left_q <= '0;
            flight_q     <= '0;
            inflight_q   <= '0;
            in_w_q       <= '0;
            wt_w_q       <= '0;
            s_in_q       <= 1'b0;
            s_wt_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            flight_q     <= flight_d;
            inflight_q   <= inflight_d;
            err_q        <= reject_start;
            if (accept_start) begin
                in_w_q <= in_p;
                wt_w_q <= wt_p;
                s_in_q <= bus.cfg_s_in;
                s_wt_q <= bus.cfg_s_weight;
            end
        end
    end

    fusion_res_fifo #(
        .WIDTH (PSUM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bus.arr_psum),
        .pop       (pop),
        .pop_data  (bus.res_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.busy             = (state_q != S_IDLE);
    assign bus.done             = (state_q == S_DONE);
    assign bus.err              = err_q;
    assign bus.op_ready         = op_ready;
    assign bus.arr_feed         = feed;
    assign bus.arr_in_width     = in_w_q;
    assign bus.arr_weight_width = wt_w_q;
    assign bus.arr_s_in         = s_in_q;
    assign bus.arr_s_weight     = s_wt_q;
    assign bus.res_valid        = !fifo_empty;

`ifdef FUSION_CTRL_PERF_EN
    logic [31:0] stall_q, beats_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            beats_q <= '0;
        end else if (accept_start) begin
            stall_q <= '0;
            beats_q <= '0;
        end else begin
            if ((state_q == S_RUN) && bus.op_valid && !op_ready) begin
                stall_q <= stall_q + 32'd1;
            end
            if (feed) begin
                beats_q <= beats_q + 32'd1;
            end
        end
    end

    assign bus.perf_stall_cycles = stall_q;
    assign bus.perf_beats        = beats_q;
`endif

endmodule

// File: tb/tb_fusion_array_ctrl.sv
// tb/tb_fusion_array_ctrl.sv - directed self-checking bench for fusion_array_ctrl
module tb_fusion_array_ctrl;
    import fusion_pkg::*;

    localparam int ROWS       = 8;
    localparam int COL_WIDTH  = 11;
    localparam int LEN_W      = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int PSUM_W     = 4*COL_WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fusion_array_ctrl_if #(.COL_WIDTH(COL_WIDTH), .LEN_W(LEN_W)) bus ();

    fusion_array_ctrl #(
        .ROWS       (ROWS),
        .COL_WIDTH  (COL_WIDTH),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fed = 0, popped = 0, done_cnt = 0, err_cnt = 0;
    int last_pop_cyc = 0, done_cyc = 0, t_feed = 0;
    int f0, p0, d0, e0;
    bit lat_chk = 1'b0;
    int feed_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Array model: the psum leaving the column is a known function of the cycle it is sampled in.
    function automatic logic [PSUM_W-1:0] psum_of(input int c);
        logic [31:0] h;
        h = 32'(c) * 32'h9E37_79B1;
        return {12'(c), h};
    endfunction

    assign bus.arr_psum = psum_of(cyc);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            feed_q.delete();
        end else begin
            if (bus.arr_feed) begin
                feed_q.push_back(cyc);
                fed++;
            end
            if (bus.res_valid && bus.res_ready) begin
                popped++;
                last_pop_cyc = cyc;
                check_eq("pop_has_feed", 64'(feed_q.size() != 0), 64'd1);
                if (feed_q.size() != 0) begin
                    t_feed = feed_q.pop_front();
                    check_eq("res_data", bus.res_data, psum_of(t_feed + ROWS));
                    if (lat_chk) check_eq("res_latency", 64'(cyc - t_feed), 64'(ROWS + 1));
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.err) err_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [3:0] iw, input logic [3:0] ww,
                             input logic si, input logic sw, input logic [LEN_W-1:0] k);
        bus.cfg_in_width     = iw;
        bus.cfg_weight_width = ww;
        bus.cfg_s_in         = si;
        bus.cfg_s_weight     = sw;
        bus.cfg_len          = k;
        bus.start            = 1'b1;
        tick(1);
        bus.start            = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d_start = done_cnt;
        int n = 0;
        while (done_cnt == d_start && n < budget) begin
            @(posedge clk);
            n++;
        end
        check_eq(tag, 64'(done_cnt - d_start), 64'd1);
        tick(1);
    endtask

    task automatic snap();
        f0 = fed; p0 = popped; d0 = done_cnt; e0 = err_cnt;
    endtask

    initial begin
        bus.start = 1'b0; bus.cfg_in_width = '0; bus.cfg_weight_width = '0;
        bus.cfg_s_in = 1'b0; bus.cfg_s_weight = 1'b0; bus.cfg_len = '0;
        bus.op_valid = 1'b0; bus.res_ready = 1'b1;
        tick(1);
        check_eq("rst_ctrl", {bus.busy, bus.done, bus.err, bus.op_ready, bus.res_valid,
                              bus.arr_feed, bus.arr_s_in, bus.arr_s_weight}, 64'd0);
        check_eq("rst_arr_width", {bus.arr_in_width, bus.arr_weight_width}, 64'd0);
        check_eq("rst_res_data", bus.res_data, 64'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // 8x8, K=5: five beats, each result ROWS+1 cycles after its feed
        lat_chk = 1'b1; bus.op_valid = 1'b1; snap();
        start_job(W8, W8, 1'b0, 1'b0, 16'd5);
        check_eq("t1_op_ready_first", bus.op_ready, 64'd1);
        check_eq("t1_arr_width", {bus.arr_in_width, bus.arr_weight_width}, 64'h88);
        wait_done("t1_done", 100);
        check_eq("t1_beats", 64'(fed - f0), 64'd5);
        check_eq("t1_results", 64'(popped - p0), 64'd5);
        check_eq("t1_done_after_pop", 64'(done_cyc - last_pop_cyc), 64'd1);
        tick(3);
        check_eq("t1_done_once", 64'(done_cnt - d0), 64'd1);
        check_eq("t1_idle", bus.busy, 64'd0);

        // in=2, weight=1 (promoted), K=9: 4 lanes -> 3 beats
        snap();
        start_job(W2, W1, 1'b1, 1'b0, 16'd9);
        check_eq("t2_arr_cfg", {bus.arr_in_width, bus.arr_weight_width, bus.arr_s_in, bus.arr_s_weight},
                 64'b0010_0010_1_0);
        wait_done("t2_done", 100);
        check_eq("t2_beats", 64'(fed - f0), 64'd3);
        check_eq("t2_results", 64'(popped - p0), 64'd3);

        // Back-pressure: consumer stalled, credits run out at FIFO_DEPTH beats
        lat_chk = 1'b0; bus.res_ready = 1'b0; snap();
        start_job(W8, W8, 1'b0, 1'b0, 16'd64);
        tick(40);
        check_eq("t3_beats_stalled", 64'(fed - f0), 64'(FIFO_DEPTH));
        check_eq("t3_op_ready_low", bus.op_ready, 64'd0);
        check_eq("t3_res_valid", {bus.res_valid, bus.busy}, 64'b11);
        bus.res_ready = 1'b1;
        wait_done("t3_done", 400);
        check_eq("t3_beats", 64'(fed - f0), 64'd64);
        check_eq("t3_results", 64'(popped - p0), 64'd64);

        // Illegal width: err pulse, never busy, no beats
        snap();
        start_job(4'b0011, W8, 1'b0, 1'b0, 16'd5);
        for (int i = 0; i < 4; i++) begin
            check_eq("t4_quiet", {bus.busy, bus.op_ready}, 64'd0);
            tick(1);
        end
        check_eq("t4_err_pulses", 64'(err_cnt - e0), 64'd1);
        check_eq("t4_beats", 64'(fed - f0), 64'd0);

        // K=0: done the cycle after start, for one cycle
        snap();
        start_job(W4, W4, 1'b0, 1'b0, 16'd0);
        check_eq("t5_done", {bus.done, bus.busy}, 64'b11);
        tick(1);
        check_eq("t5_done_end", {bus.done, bus.busy}, 64'b00);
        check_eq("t5_beats", 64'(fed - f0), 64'd0);
        check_eq("t5_done_count", 64'(done_cnt - d0), 64'd1);

        // Reset mid-run, then a fresh job
        lat_chk = 1'b1;
        start_job(W8, W8, 1'b0, 1'b0, 16'd64);
        tick(12);
        check_eq("t6_pre_reset_valid", bus.res_valid, 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_ctrl", {bus.busy, bus.done, bus.err, bus.op_ready, bus.res_valid,
                                 bus.arr_feed, bus.arr_s_in, bus.arr_s_weight}, 64'd0);
        check_eq("t6_rst_arr", {bus.arr_in_width, bus.arr_weight_width}, 64'd0);
        check_eq("t6_rst_data", bus.res_data, 64'd0);
        bus.op_valid = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        bus.op_valid = 1'b1; snap();
        start_job(W8, W4, 1'b0, 1'b1, 16'd5);
        wait_done("t6_done", 100);
        check_eq("t6_beats", 64'(fed - f0), 64'd5);
        check_eq("t6_results", 64'(popped - p0), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
